// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: byte-strobed output register with atomic set/clear,
// debounced inputs, and edge interrupts compiled in when GPIO_IRQ_EN is defined.
module mmio_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          OUT_W     = 6,
    parameter int          IN_W      = 2,
    parameter int          DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic              re,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [IN_W-1:0]   gpio_in,
    output logic [OUT_W-1:0]  gpio_out,
    output logic              irq
);

    localparam int            CW    = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DB_CYCLES - 1);

    localparam logic [3:0] OFF_OUT      = 4'h0;
    localparam logic [3:0] OFF_SET      = 4'h1;
    localparam logic [3:0] OFF_CLR      = 4'h2;
    localparam logic [3:0] OFF_IN       = 4'h3;
    localparam logic [3:0] OFF_IRQ_PEND = 4'h4;
    localparam logic [3:0] OFF_IRQ_EN   = 4'h5;
    localparam logic [3:0] OFF_IRQ_EDGE = 4'h6;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        sel;
    logic        wr;
    logic        rd;
    logic [3:0]  off;
    logic [31:0] bmask;
    logic [31:0] wbits;

    assign sel   = (addr[31:6] == BASE_ADDR[31:6]);
    assign off   = addr[5:2];
    assign wr    = sel && (wstrb != 4'b0000);
    assign rd    = sel && re;
    assign bmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign wbits = wdata & bmask;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_nxt;

    always_comb begin
        out_nxt = out_q;
        if (wr) begin
            case (off)
                OFF_OUT: out_nxt = (out_q & ~bmask[OUT_W-1:0]) | wbits[OUT_W-1:0];
                OFF_SET: out_nxt = out_q | wbits[OUT_W-1:0];
                OFF_CLR: out_nxt = out_q & ~wbits[OUT_W-1:0];
                default: out_nxt = out_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_nxt;
        end
    end

    assign gpio_out = out_q;

    // ------------------------------------------------------------------
    // Input synchroniser and per-bit debounce
    // ------------------------------------------------------------------
    logic [IN_W-1:0] meta_q;
    logic [IN_W-1:0] sync_q;
    logic [IN_W-1:0] db_q;
    logic [IN_W-1:0] db_nxt;
    logic [CW-1:0]   cnt_q   [IN_W];
    logic [CW-1:0]   cnt_nxt [IN_W];

    // A differing sample must persist for DB_CYCLES consecutive cycles;
    // any return to the accepted level restarts the count.
    always_comb begin
        db_nxt = db_q;
        for (int i = 0; i < IN_W; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (sync_q[i] == db_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt_q[i] == C_MAX) begin
                db_nxt[i]  = sync_q[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            for (int i = 0; i < IN_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q <= gpio_in;
            sync_q <= meta_q;
            db_q   <= db_nxt;
            for (int i = 0; i < IN_W; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef GPIO_IRQ_EN
    // ------------------------------------------------------------------
    // Edge-triggered interrupt pending / enable
    // ------------------------------------------------------------------
    logic [IN_W-1:0] pend_q;
    logic [IN_W-1:0] pend_nxt;
    logic [IN_W-1:0] en_q;
    logic [IN_W-1:0] en_nxt;
    logic [IN_W-1:0] edge_q;
    logic [IN_W-1:0] edge_nxt;
    logic [IN_W-1:0] edge_hit;
    logic [IN_W-1:0] pend_clr;
    logic            irq_q;

    // Edge is taken from db_nxt so the flag lands in the same cycle d changes.
    assign edge_hit = (~edge_q & ~db_q &  db_nxt) |
                      ( edge_q &  db_q & ~db_nxt);

    always_comb begin
        pend_clr = '0;
        en_nxt   = en_q;
        edge_nxt = edge_q;
        if (wr) begin
            case (off)
                OFF_IRQ_PEND: pend_clr = wbits[IN_W-1:0];
                OFF_IRQ_EN:   en_nxt   = (en_q & ~bmask[IN_W-1:0]) | wbits[IN_W-1:0];
                OFF_IRQ_EDGE: edge_nxt = (edge_q & ~bmask[IN_W-1:0]) | wbits[IN_W-1:0];
                default: ;
            endcase
        end
        // A new edge in the same cycle as the W1C wins.
        pend_nxt = (pend_q & ~pend_clr) | edge_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            en_q   <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            en_q   <= en_nxt;
            edge_q <= edge_nxt;
            irq_q  <= |(pend_q & en_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path: registered, holds when idle, returns pre-write contents
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_OUT: rd_val[OUT_W-1:0] = out_q;
            OFF_IN:  rd_val[IN_W-1:0]  = db_q;
`ifdef GPIO_IRQ_EN
            OFF_IRQ_PEND: rd_val[IN_W-1:0] = pend_q;
            OFF_IRQ_EN:   rd_val[IN_W-1:0] = en_q;
            OFF_IRQ_EDGE: rd_val[IN_W-1:0] = edge_q;
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= rd_val;
        end
    end

    // Byte offset bits and upper data bits beyond the register widths are don't-care.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wbits, bmask, wdata};

endmodule
